// File: rtl/spi_capture_pkg.sv
// Shared types and constants for the SPI frame capture block.
package spi_capture_pkg;

   localparam int SWORD_DEF = 32;

   localparam logic [7:0] ASCII_O = 8'd79;
   localparam logic [7:0] ASCII_K = 8'd75;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } cap_state_t;

endpackage

// File: rtl/spi_frame_capture_sync_fifo.sv
// First-word fall-through FIFO; head visible the cycle after push into an empty FIFO.
// Backpressure: push while full with no pop is dropped and flagged on drop.
module sync_fifo #(
   parameter int sword = 32,
   parameter int depth = 8
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         push,
   input  logic [sword-1:0]             push_data,
   input  logic                         pop,
   output logic [sword-1:0]             head,
   output logic                         valid,
   output logic                         full,
   output logic                         drop,
   output logic [$clog2(depth+1)-1:0]   count
);

   localparam int AW = $clog2(depth);
   localparam int CW = $clog2(depth+1);

   logic [sword-1:0] mem [depth];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign valid   = (count != '0);
   assign full    = (count == CW'(depth));
   assign do_pop  = pop & valid;
   // a full FIFO still accepts a word when the head leaves in the same cycle
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;
   assign head    = valid ? mem[rptr] : '0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem[wptr] <= push_data;
   end

endmodule

// File: rtl/spi_frame_capture.sv
// Deserialises CEB-framed SPI words MSB-first into a FWFT FIFO; push lands 3 CLK after CEB is sampled high.
// Backpressure: m_ready low holds the head word; a commit into a full FIFO is dropped and sets overflow.
module spi_frame_capture
   import spi_capture_pkg::*;
#(
   parameter int sword = SWORD_DEF,
   parameter int depth = 8
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         spi_CEB,
   input  logic                         spi_SCLK,
   input  logic                         spi_DATA,
   output logic [sword-1:0]             m_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [$clog2(depth+1)-1:0]   m_count,
   output logic                         overflow,
   output logic                         ok_seen,
   input  logic                         clear
);

   localparam int BW = $clog2(sword+1);

   // [0],[1] synchronise, [2] is the previous value for edge detection
   logic [2:0]       ceb_q;
   logic [2:0]       sclk_q;
   logic [1:0]       data_q;
   logic             ceb_fall;
   logic             ceb_rise;
   logic             sclk_rise;

   cap_state_t       state;
   cap_state_t       state_nxt;
   logic             start;
   logic             shift_en;
   logic             push;

   logic [sword-1:0] cap;
   logic [BW-1:0]    bit_cnt;
   logic [sword-1:0] prev_word;
   logic             full;
   logic             drop;
   logic             ok_set;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ceb_q  <= 3'b111;
         sclk_q <= '0;
         data_q <= '0;
      end else begin
         ceb_q  <= {ceb_q[1:0], spi_CEB};
         sclk_q <= {sclk_q[1:0], spi_SCLK};
         data_q <= {data_q[0], spi_DATA};
      end
   end

   assign ceb_fall  = ~ceb_q[1] &  ceb_q[2];
   assign ceb_rise  =  ceb_q[1] & ~ceb_q[2];
   assign sclk_rise =  sclk_q[1] & ~sclk_q[2];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      shift_en  = 1'b0;
      push      = 1'b0;
      case (state)
         IDLE: begin
            if (ceb_fall) begin
               start     = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = sclk_rise;
            if (ceb_rise) state_nxt = COMMIT;
         end
         COMMIT: begin
            push      = (bit_cnt != '0);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // counter saturates but shifting continues, so an over-long frame keeps its last sword bits
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cap     <= '0;
         bit_cnt <= '0;
      end else if (start) begin
         cap     <= '0;
         bit_cnt <= '0;
      end else if (shift_en) begin
         cap <= {cap[sword-2:0], data_q[1]};
         if (bit_cnt != BW'(sword)) bit_cnt <= bit_cnt + BW'(1);
      end
   end

   sync_fifo #(
      .sword (sword),
      .depth (depth)
   ) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .push      (push),
      .push_data (cap),
      .pop       (m_ready),
      .head      (m_data),
      .valid     (m_valid),
      .full      (full),
      .drop      (drop),
      .count     (m_count)
   );

   // dropped words still take part in the terminator match
   assign ok_set = push && (prev_word == sword'(ASCII_O)) && (cap == sword'(ASCII_K));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         prev_word <= '0;
         ok_seen   <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (push)       prev_word <= cap;
         else if (clear) prev_word <= '0;

         if (ok_set)     ok_seen <= 1'b1;
         else if (clear) ok_seen <= 1'b0;

         if (drop)       overflow <= 1'b1;
         else if (clear) overflow <= 1'b0;
      end
   end

   logic unused_full;
   assign unused_full = full;

endmodule

// File: tb/tb_spi_frame_capture.sv
// Self-checking bench: vector table, directed corner cases and randomised frames against a queue model.
module tb_spi_frame_capture;

   logic        CLK = 1'b0;
   logic        RST;
   logic        spi_CEB;
   logic        spi_SCLK;
   logic        spi_DATA;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic [3:0]  m_count;
   logic        overflow;
   logic        ok_seen;
   logic        clear;

   spi_frame_capture #(.sword(32), .depth(8)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .spi_CEB  (spi_CEB),
      .spi_SCLK (spi_SCLK),
      .spi_DATA (spi_DATA),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_count  (m_count),
      .overflow (overflow),
      .ok_seen  (ok_seen),
      .clear    (clear)
   );

   always #5 CLK = ~CLK;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] expq[$];
   logic [31:0] prev_m   = 32'd0;
   bit          ok_exp   = 1'b0;
   bit          ov_exp   = 1'b0;
   bit          rand_ready_en = 1'b0;

   typedef struct {
      logic [63:0] w;
      int          n;
      logic [31:0] e;
      bit          has;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // every accepted beat must be the oldest word the model still expects
   always @(negedge CLK) begin
      if (!RST && m_valid && m_ready) begin
         if (expq.size() == 0) begin
            chk("unexpected_beat", {32'd0, m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            logic [31:0] e;
            e = expq.pop_front();
            chk("beat_data", {32'd0, m_data}, {32'd0, e});
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      if (rand_ready_en) m_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic model_commit(input logic [31:0] e, input bit pop_same);
      if (prev_m == 32'd79 && e == 32'd75) ok_exp = 1'b1;
      prev_m = e;
      if (expq.size() < 8 || pop_same) expq.push_back(e);
      else ov_exp = 1'b1;
   endtask

   task automatic shift_bits(input logic [63:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         spi_DATA = w[i];
         repeat (3) tick();
         spi_SCLK = 1'b1;
         repeat (3) tick();
         spi_SCLK = 1'b0;
      end
   endtask

   // mode 0: plain, 1: one-cycle pop on the commit edge, 2: latency check
   task automatic send_frame(input logic [63:0] w, input int n, input int mode,
                             input logic [31:0] e, input bit has);
      spi_CEB = 1'b0;
      repeat (4) tick();
      shift_bits(w, n);
      repeat (3) tick();
      if (has) model_commit(e, mode == 1);
      spi_CEB = 1'b1;
      if (mode == 1) begin
         repeat (3) tick();
         m_ready = 1'b1;
         tick();
         m_ready = 1'b0;
      end else if (mode == 2) begin
         repeat (3) tick();
         chk("latency_early", {63'd0, m_valid}, 64'd0);
         tick();
         chk("latency_valid", {63'd0, m_valid}, 64'd1);
         chk("latency_data", {32'd0, m_data}, {32'd0, e});
      end
      repeat (6) tick();
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      ok_exp = 1'b0;
      ov_exp = 1'b0;
      prev_m = 32'd0;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_m_data"},   {32'd0, m_data},   64'd0);
      chk({tag, "_m_valid"},  {63'd0, m_valid},  64'd0);
      chk({tag, "_m_count"},  {60'd0, m_count},  64'd0);
      chk({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
      chk({tag, "_ok_seen"},  {63'd0, ok_seen},  64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{64'h0000_0000_1234_5678, 32, 32'h1234_5678, 1'b1};
      tbl[1] = '{64'h0000_0000_0000_004F,  8, 32'h0000_004F, 1'b1};
      tbl[2] = '{64'h0000_0000_000A_BCDE, 20, 32'h000A_BCDE, 1'b1};
      tbl[3] = '{64'h0000_0011_DEAD_BEEF, 40, 32'hDEAD_BEEF, 1'b1};
      tbl[4] = '{64'h0000_0000_0000_0001,  1, 32'h0000_0001, 1'b1};
      tbl[5] = '{64'h0000_FFF0_0000_0001, 33, 32'h0000_0001, 1'b1};

      RST      = 1'b1;
      spi_CEB  = 1'b1;
      spi_SCLK = 1'b0;
      spi_DATA = 1'b0;
      m_ready  = 1'b0;
      clear    = 1'b0;
      repeat (3) tick();
      check_idle_outputs("reset");
      RST = 1'b0;
      repeat (4) tick();

      // vector table, consumer always ready
      m_ready = 1'b1;
      for (int v = 0; v < 6; v++) begin
         send_frame(tbl[v].w, tbl[v].n, (v == 0) ? 2 : 0, tbl[v].e, tbl[v].has);
         chk("table_count", {60'd0, m_count}, 64'd0);
         chk("table_drained", 64'(expq.size()), 64'd0);
      end
      pulse_clear();

      // terminator detection and clear
      send_frame(64'd79, 8, 0, 32'd79, 1'b1);
      send_frame(64'd75, 8, 0, 32'd75, 1'b1);
      chk("ok_set", {63'd0, ok_seen}, 64'd1);
      pulse_clear();
      chk("ok_cleared", {63'd0, ok_seen}, 64'd0);
      send_frame(64'd79, 8, 0, 32'd79, 1'b1);
      send_frame(64'd65, 8, 0, 32'd65, 1'b1);
      send_frame(64'd75, 8, 0, 32'd75, 1'b1);
      chk("ok_broken", {63'd0, ok_seen}, 64'd0);

      // overflow with consumer stalled
      m_ready = 1'b0;
      for (int k = 1; k <= 9; k++) send_frame(64'(k), 8, 0, 32'(k), 1'b1);
      chk("ovf_count", {60'd0, m_count}, 64'd8);
      chk("ovf_flag", {63'd0, overflow}, 64'd1);
      chk("ovf_head_held", {32'd0, m_data}, 64'd1);
      m_ready = 1'b1;
      repeat (12) tick();
      chk("ovf_drained", 64'(expq.size()), 64'd0);
      chk("ovf_count_zero", {60'd0, m_count}, 64'd0);
      pulse_clear();
      chk("ovf_cleared", {63'd0, overflow}, 64'd0);

      // full FIFO with a pop on the commit edge
      m_ready = 1'b0;
      for (int k = 1; k <= 8; k++) send_frame(64'(k), 8, 0, 32'(k), 1'b1);
      send_frame(64'd9, 8, 1, 32'd9, 1'b1);
      chk("fullpop_count", {60'd0, m_count}, 64'd8);
      chk("fullpop_no_ovf", {63'd0, overflow}, 64'd0);
      chk("fullpop_head", {32'd0, m_data}, 64'd2);
      m_ready = 1'b1;
      repeat (12) tick();
      chk("fullpop_drained", 64'(expq.size()), 64'd0);

      // empty frame produces nothing
      m_ready = 1'b0;
      send_frame(64'd0, 0, 0, 32'd0, 1'b0);
      chk("empty_valid", {63'd0, m_valid}, 64'd0);
      chk("empty_count", {60'd0, m_count}, 64'd0);
      m_ready = 1'b1;

      // reset in the middle of a frame, with sticky flags set beforehand
      send_frame(64'd79, 8, 0, 32'd79, 1'b1);
      send_frame(64'd75, 8, 0, 32'd75, 1'b1);
      chk("pre_reset_ok", {63'd0, ok_seen}, 64'd1);
      spi_CEB = 1'b0;
      repeat (4) tick();
      shift_bits(64'hFFF, 12);
      RST = 1'b1;
      tick();
      spi_CEB = 1'b1;
      check_idle_outputs("midframe_reset");
      repeat (3) tick();
      RST = 1'b0;
      expq.delete();
      ok_exp = 1'b0;
      ov_exp = 1'b0;
      prev_m = 32'd0;
      repeat (4) tick();
      send_frame(64'hA5A5_A5A5, 32, 0, 32'hA5A5_A5A5, 1'b1);
      chk("post_reset_drained", 64'(expq.size()), 64'd0);
      chk("post_reset_count", {60'd0, m_count}, 64'd0);

      // randomised frames against the queue model
      rand_ready_en = 1'b1;
      for (int r = 0; r < 30; r++) begin
         logic [63:0] w;
         logic [63:0] mask;
         int          n;
         int          k;
         if ($urandom_range(0, 2) == 0) begin
            w = ($urandom_range(0, 1) == 0) ? 64'd79 : 64'd75;
            n = 8;
         end else begin
            w = {$urandom, $urandom};
            n = $urandom_range(0, 40);
         end
         k    = (n > 32) ? 32 : n;
         mask = (64'd1 << k) - 64'd1;
         send_frame(w, n, 0, 32'(w & mask), n > 0);
         chk("rand_ok_seen", {63'd0, ok_seen}, {63'd0, ok_exp});
      end
      rand_ready_en = 1'b0;
      m_ready = 1'b1;
      repeat (20) tick();
      chk("rand_drained", 64'(expq.size()), 64'd0);
      chk("rand_overflow", {63'd0, overflow}, {63'd0, ov_exp});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
